// File: rtl/timer_pkg.sv
// Shared types for the memory-mapped interval timer: register offsets,
// CTRL layout and the count state encoding.
package timer_pkg;

  typedef enum logic [2:0] {
    CTRL     = 3'd0,
    RELOAD   = 3'd1,
    COUNT    = 3'd2,
    STATUS   = 3'd3,
    PRESCALE = 3'd4
  } timer_reg_e;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

  localparam int unsigned STATUS_PENDING_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock divider: emits a one-cycle tick every divisor+1 cycles
// while enabled, holding its counter at 0 otherwise.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] divisor,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] cnt_d;
  logic                      at_div_s;

  assign at_div_s = (cnt_q == divisor);
  // A tick in a clear cycle still fires; clear only restarts the count.
  assign tick     = enable & at_div_s;

  // Divider counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (at_div_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  // Divider counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit down-counting interval timer with prescaler,
// auto-reload and a level interrupt acknowledged by write-1-to-clear.
module mmio_timer
  import timer_pkg::*;
#(
  parameter int ADDR_BITS      = 3,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 hwint
);

  timer_ctrl_t               ctrl_q, ctrl_d;
  logic [31:0]               reload_q, reload_d;
  logic [31:0]               count_q, count_d;
  logic                      pending_q, pending_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;

  timer_state_e state_s;
  logic         wr_s;
  logic         wr_ctrl_s;
  logic         wr_count_s;
  logic         wr_status_s;
  logic         wr_prescale_s;
  logic         tick_s;

  assign wr_s          = en & mem_wr;
  assign wr_ctrl_s     = wr_s & (addr == ADDR_BITS'(CTRL));
  assign wr_count_s    = wr_s & (addr == ADDR_BITS'(COUNT));
  assign wr_status_s   = wr_s & (addr == ADDR_BITS'(STATUS));
  assign wr_prescale_s = wr_s & (addr == ADDR_BITS'(PRESCALE));
  assign state_s       = ctrl_q.enable ? RUN : IDLE;
  assign hwint         = pending_q & ctrl_q.irq_en;

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (ctrl_q.enable),
    .clear  (wr_ctrl_s | wr_prescale_s),
    .divisor(prescale_q),
    .tick   (tick_s)
  );

  // Next state: acknowledge, then tick/expiry, then bus writes override fields
  always_comb begin
    ctrl_d     = ctrl_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pending_d  = pending_q;
    prescale_d = prescale_q;

    if (wr_status_s && data_in[STATUS_PENDING_BIT]) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    case (state_s)
      RUN: begin
        // A COUNT write in a tick cycle swallows the tick entirely.
        if (tick_s && !wr_count_s) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            pending_d = 1'b1;
            if (ctrl_q.auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d       = 32'd0;
              ctrl_d.enable = 1'b0;
            end
          end
        end else begin
          count_d = count_q;
        end
      end
      IDLE:    count_d = count_q;
      default: count_d = count_q;
    endcase

    if (wr_s) begin
      case (addr)
        ADDR_BITS'(CTRL):     ctrl_d     = timer_ctrl_t'(data_in[2:0]);
        ADDR_BITS'(RELOAD):   reload_d   = data_in;
        ADDR_BITS'(COUNT):    count_d    = data_in;
        ADDR_BITS'(PRESCALE): prescale_d = data_in[PRESCALE_WIDTH-1:0];
        default: ;
      endcase
    end else begin
      reload_d = reload_q;
    end
  end

  // Register file with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= timer_ctrl_t'(3'd0);
      reload_q   <= 32'd0;
      count_q    <= 32'd0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
    end
  end

  // Combinational read mux; shows pre-write values on a simultaneous write
  always_comb begin
    data_out = 32'd0;
    if (en && mem_rd) begin
      case (addr)
        ADDR_BITS'(CTRL):     data_out = {29'd0, ctrl_q};
        ADDR_BITS'(RELOAD):   data_out = reload_q;
        ADDR_BITS'(COUNT):    data_out = count_q;
        ADDR_BITS'(STATUS):   data_out = {31'd0, pending_q};
        ADDR_BITS'(PRESCALE): data_out = 32'(prescale_q);
        default:              data_out = 32'd0;
      endcase
    end else begin
      data_out = 32'd0;
    end
  end

endmodule
